// File: rtl/c3_path_pkg.sv
// Shared definitions for c3_path_pipe: lane gate modes and the per-lane evaluator.
package c3_path_pkg;

    typedef enum logic [1:0] {
        MODE_BUF   = 2'b00,
        MODE_INV   = 2'b01,
        MODE_NAND2 = 2'b10,
        MODE_XOR2  = 2'b11
    } mode_t;

    function automatic logic lane_eval(input mode_t mode, input logic a, input logic b);
        logic z;
        case (mode)
            MODE_BUF:   z = a;
            MODE_INV:   z = ~a;
            MODE_NAND2: z = ~(a & b);
            default:    z = a ^ b;
        endcase
        return z;
    endfunction

endpackage

// File: rtl/c3_path_stage.sv
// One elastic pipeline register slice: valid bit plus data word (parity rides in the data word).
module c3_path_stage #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready_dn
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_adv;

    assign w_adv   = !r_valid || i_ready_dn;
    assign o_ready = w_adv;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_adv) begin
            r_valid <= i_valid;
            if (i_valid)
                r_data <= i_data;
        end
    end

endmodule

// File: rtl/c3_path_pipe.sv
// Per-lane programmable gate followed by a DEPTH-stage elastic valid/ready pipeline.
// Optional parity carry/check is enabled by defining C3_PATH_PIPE_PARITY_EN.
module c3_path_pipe
    import c3_path_pkg::*;
#(
    parameter  int LANES = 4,
    parameter  int DEPTH = 2,
    localparam int OW    = $clog2(DEPTH + 1)
) (
    input  logic               tau2015_clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES-1:0]   in_a,
    input  logic [LANES-1:0]   in_b,
    input  logic               cfg_we,
    input  logic [2*LANES-1:0] cfg_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES-1:0]   out_z,
    output logic [OW-1:0]      occupancy
`ifdef C3_PATH_PIPE_PARITY_EN
    ,
    input  logic               chk_en,
    output logic               out_par,
    output logic               par_err
`endif
);

`ifdef C3_PATH_PIPE_PARITY_EN
    localparam int DW = LANES + 1;
`else
    localparam int DW = LANES;
`endif

    logic [2*LANES-1:0]       r_mode;
    logic [LANES-1:0]         w_res;
    logic [DEPTH:0]           w_vld;
    logic [DEPTH:0]           w_rdy;
    logic [DEPTH:0][DW-1:0]   w_dat;
    logic [DW-1:0]            w_last;
    logic                     w_acc;
    logic                     w_emit;
    logic [OW-1:0]            r_occ;

    // Beats accepted alongside cfg_we see the old modes since r_mode updates at the edge.
    always_ff @(posedge tau2015_clk) begin
        if (rst)
            r_mode <= '0;
        else if (cfg_we)
            r_mode <= cfg_mode;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign w_res[i] = lane_eval(mode_t'(r_mode[2*i +: 2]), in_a[i], in_b[i]);
    end

`ifdef C3_PATH_PIPE_PARITY_EN
    assign w_dat[0] = {^w_res, w_res};
`else
    assign w_dat[0] = w_res;
`endif
    assign w_vld[0]     = in_valid;
    assign w_rdy[DEPTH] = out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stg
        c3_path_stage #(.W(DW)) u_stg (
            .clk        (tau2015_clk),
            .rst        (rst),
            .i_valid    (w_vld[k]),
            .i_data     (w_dat[k]),
            .o_ready    (w_rdy[k]),
            .o_valid    (w_vld[k+1]),
            .o_data     (w_dat[k+1]),
            .i_ready_dn (w_rdy[k+1])
        );
    end

    assign w_last    = w_dat[DEPTH];
    assign in_ready  = w_rdy[0];
    assign out_valid = w_vld[DEPTH];
    assign out_z     = w_last[LANES-1:0];
    assign w_acc     = in_valid && in_ready;
    assign w_emit    = out_valid && out_ready;
    assign occupancy = r_occ;

    always_ff @(posedge tau2015_clk) begin
        if (rst)
            r_occ <= '0;
        else if (w_acc && !w_emit)
            r_occ <= r_occ + OW'(1);
        else if (w_emit && !w_acc)
            r_occ <= r_occ - OW'(1);
    end

`ifdef C3_PATH_PIPE_PARITY_EN
    logic r_par_err;

    assign out_par = w_last[LANES];
    assign par_err = r_par_err;

    always_ff @(posedge tau2015_clk) begin
        if (rst)
            r_par_err <= 1'b0;
        else if (chk_en && out_valid && ((^w_last[LANES-1:0]) != w_last[LANES]))
            r_par_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_c3_path_pipe.sv
// Scoreboard bench for c3_path_pipe (LANES=4, DEPTH=2); parity checks compile with C3_PATH_PIPE_PARITY_EN.
module tb_c3_path_pipe;

    localparam int LANES = 4;
    localparam int DEPTH = 2;
    localparam int OW    = $clog2(DEPTH + 1);

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [LANES-1:0]   in_a;
    logic [LANES-1:0]   in_b;
    logic               cfg_we;
    logic [2*LANES-1:0] cfg_mode;
    logic               out_valid;
    logic               out_ready;
    logic [LANES-1:0]   out_z;
    logic [OW-1:0]      occupancy;
`ifdef C3_PATH_PIPE_PARITY_EN
    logic               chk_en;
    logic               out_par;
    logic               par_err;
`endif

    logic [LANES-1:0]   exp_z;
    logic [LANES-1:0]   q[$];
    int                 n_chk  = 0;
    int                 n_pass = 0;
    int                 n_emit = 0;

    c3_path_pipe #(.LANES(LANES), .DEPTH(DEPTH)) dut (
        .tau2015_clk (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .cfg_we      (cfg_we),
        .cfg_mode    (cfg_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_z       (out_z),
        .occupancy   (occupancy)
`ifdef C3_PATH_PIPE_PARITY_EN
        ,
        .chk_en      (chk_en),
        .out_par     (out_par),
        .par_err     (par_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop on output handshake, push on input handshake; reset flushes in-flight beats.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_emit++;
                if (q.size() == 0)
                    chk("sb_unexpected_beat", 32'(out_z), 32'hDEAD);
                else
                    chk("sb_out_z", 32'(out_z), 32'(q.pop_front()));
            end
            if (in_valid && in_ready)
                q.push_back(exp_z);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        cfg_we = 1'b0; cfg_mode = '0; out_ready = 1'b0; exp_z = '0;
`ifdef C3_PATH_PIPE_PARITY_EN
        chk_en = 1'b0;
`endif
        tick; tick;
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_z",     32'(out_z),     32'd0);
        chk("rst_occ",       32'(occupancy), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        // 1: BUF streaming, latency 2, occupancy ramp
        in_valid = 1'b1; in_a = 4'b1010; exp_z = 4'b1010; out_ready = 1'b1;
        tick;
        chk("t1_occ1",   32'(occupancy), 32'd1);
        chk("t1_vld_t1", 32'(out_valid), 32'd0);
        tick;
        chk("t1_occ2",   32'(occupancy), 32'd2);
        chk("t1_vld_t2", 32'(out_valid), 32'd1);
        chk("t1_z_t2",   32'(out_z),     32'hA);
        tick;
        chk("t1_occ_steady", 32'(occupancy), 32'd2);
        in_valid = 1'b0;
        tick; tick; tick;
        chk("t1_drained", 32'(occupancy), 32'd0);

        // 2: mixed modes
        cfg_we = 1'b1; cfg_mode = 8'b11_10_01_00;
        tick;
        cfg_we = 1'b0;
        in_valid = 1'b1; in_a = 4'b1111; in_b = 4'b0101; exp_z = 4'b1001;
        tick;
        in_valid = 1'b0;
        tick;
        chk("t2_z", 32'(out_z), 32'h9);
        tick; tick;

        // 3: cfg_we in the same cycle as a beat uses old modes
        cfg_we = 1'b1; cfg_mode = 8'h00;
        tick;
        cfg_mode = 8'h55; in_valid = 1'b1; in_a = 4'h3; in_b = 4'h0; exp_z = 4'h3;
        tick;
        cfg_we = 1'b0; exp_z = 4'hC;
        tick;
        in_valid = 1'b0;
        tick; tick; tick;

        // 4: backpressure with full pipeline, then release
        cfg_we = 1'b1; cfg_mode = 8'h00;
        tick;
        cfg_we = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_a = 4'd1; exp_z = 4'd1;
        tick;
        in_a = 4'd2; exp_z = 4'd2;
        tick;
        in_a = 4'd3; exp_z = 4'd3;
        chk("t4_in_ready_low", 32'(in_ready),  32'd0);
        chk("t4_occ_full",     32'(occupancy), 32'd2);
        chk("t4_vld_held",     32'(out_valid), 32'd1);
        chk("t4_z_hold",       32'(out_z),     32'd1);
        tick;
        chk("t4_z_hold2",      32'(out_z),     32'd1);
        chk("t4_in_ready_low2", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("t4_ready_chain", 32'(in_ready), 32'd1);
        tick;
        in_a = 4'd4; exp_z = 4'd4;
        chk("t4_nogap_a", 32'(out_valid), 32'd1);
        tick;
        in_a = 4'd5; exp_z = 4'd5;
        chk("t4_nogap_b", 32'(out_valid), 32'd1);
        chk("t4_occ_stream", 32'(occupancy), 32'd2);
        tick;
        in_valid = 1'b0;
        chk("t4_nogap_c", 32'(out_valid), 32'd1);
        tick; tick; tick;
        chk("t4_drained", 32'(occupancy), 32'd0);

        // 5: reset mid-stream discards beats and modes
        cfg_we = 1'b1; cfg_mode = 8'h55;
        tick;
        cfg_we = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_a = 4'h7; exp_z = 4'h8;
        tick; tick;
        chk("t5_occ_full", 32'(occupancy), 32'd2);
        chk("t5_z_inv",    32'(out_z),     32'h8);
        in_valid = 1'b0; rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_occ",       32'(occupancy), 32'd0);
        chk("t5_out_z",     32'(out_z),     32'd0);
        out_ready = 1'b1; in_valid = 1'b1; in_a = 4'h7; exp_z = 4'h7;
        tick;
        in_valid = 1'b0;
        tick;
        chk("t5_z_buf", 32'(out_z), 32'h7);
        tick; tick;
        chk("sb_empty",   32'(q.size()), 32'd0);
        chk("emit_count", 32'(n_emit),   32'd12);

`ifdef C3_PATH_PIPE_PARITY_EN
        // 6: parity carry and sticky error
        chk_en = 1'b1; in_valid = 1'b1; in_a = 4'b0111; exp_z = 4'b0111;
        tick; tick;
        chk("t6_out_par",   32'(out_par), 32'd1);
        chk("t6_no_err",    32'(par_err), 32'd0);
        force dut.w_last = 5'b0_0111;
        tick;
        release dut.w_last;
        chk("t6_err_set",   32'(par_err), 32'd1);
        in_valid = 1'b0;
        tick; tick; tick;
        chk("t6_err_stick", 32'(par_err), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("t6_err_clear", 32'(par_err), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
